datapath_sequencer: RTL and testbench
=====================================

DATAPATH_SEQUENCER -- requirements
Module: datapath_sequencer

Interface
REQ-001 SHALL: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL: reset  input  1  asynchronous, active-high reset.
REQ-003 SHALL: cmd_valid  input  1  command present; cmd_ready  output  1  sequencer idle, can accept.
REQ-004 SHALL: cmd_op  input  3  000 MOVI, 001 MOV, 010 ADD, 011 CMP, 100 AND, 101 MVN, 110/111 illegal.
REQ-005 SHALL: cmd_rd, cmd_rn, cmd_rm  input  3 each  destination, first and second source register numbers.
REQ-006 SHALL: cmd_shift  input  2  shifter code for Rm operand; cmd_imm  input  8  signed immediate for MOVI.
REQ-007 SHALL: readnum, writenum  output  3  register file read/write select; write  output  1  register file write enable.
REQ-008 SHALL: loada, loadb, loadc, loads  output  1 each  datapath register load strobes; asel  output  1  A operand forced to zero.
REQ-009 SHALL: ALUop  output  2  ALU operation; shift  output  2  shifter control; vsel  output  1  writeback source (0 = C, 1 = immediate).
REQ-010 SHALL: sximm  output  16  cmd_imm sign-extended to 16 bits; done  output  1  one-cycle completion pulse; err  output  1  one-cycle illegal-op pulse.
REQ-011 SHALL: cmd_count  output  16  completed-command counter (see Configuration).

Function
REQ-012 SHALL: states IDLE, RDA, RDB, EXEC, WB, WIMM, ERR; all outputs Moore-decoded from state and latched command fields.
REQ-013 SHALL: cmd_ready = 1 only in IDLE; command accepted on the edge where cmd_valid and cmd_ready are both 1.
REQ-014 SHALL: all cmd_* fields latched at acceptance; changes to cmd_* while busy have no effect.
REQ-015 SHALL: transitions from IDLE on accept: MOVI->WIMM; MOV, MVN->RDB; ADD, CMP, AND->RDA; illegal->ERR; no accept -> stay IDLE.
REQ-016 SHALL: RDA: readnum = rn, loada = 1 -> RDB; RDB: readnum = rm, loadb = 1 -> EXEC.
REQ-017 SHALL: EXEC: shift = latched shift, ALUop per op (MOV/ADD 00, CMP 01, AND 10, MVN 11), asel = 1 for MOV only; loadc = 1 and -> WB, except CMP: loads = 1, loadc = 0, done = 1, -> IDLE.
REQ-018 SHALL: WB: writenum = rd, vsel = 0, write = 1, done = 1 -> IDLE; WIMM: writenum = rd, vsel = 1, write = 1, done = 1 -> IDLE.
REQ-019 SHALL: ERR: done = 1, err = 1, no strobe asserted -> IDLE.
REQ-020 SHALL: latency from accept edge to done-high cycle: MOVI 1, ILLEGAL 1, MOV 3, MVN 3, CMP 3, ADD 4, AND 4.
REQ-021 SHALL: outside the states named above every strobe, write, done, err = 0, shift = 00, ALUop = 00, asel = 0, vsel = 0, readnum/writenum = 000.
REQ-022 SHALL: write asserted only in WB or WIMM, for exactly one cycle per command; never more than one write per command.
REQ-023 SHALL: back-to-back: cmd_ready returns to 1 in the cycle after done; no command accepted in the done cycle.

Reset
REQ-024 SHALL: reset forces IDLE immediately (asynchronously), cmd_ready = 1, all other outputs 0, latched fields and cmd_count cleared.
REQ-025 SHALL: reset mid-command discards the command with no write and no done pulse.

Configuration
REQ-026 SHALL: with macro DPSEQ_CMD_COUNT_EN defined, cmd_count increments by 1 on every done pulse (including err), wrapping FFFF->0000.
REQ-027 SHALL: without DPSEQ_CMD_COUNT_EN, cmd_count is constant 0 and no counter register is synthesised; all other behaviour identical.

Verification
REQ-028 SHALL: MOVI rd=3 imm=8'hF6 -> next cycle write=1, writenum=3, vsel=1, sximm=16'hFFF6, done=1; cmd_ready=1 the cycle after.
REQ-029 SHALL: ADD rd=2 rn=0 rm=1 shift=01 -> cycles: loada/readnum=0, loadb/readnum=1, loadc/ALUop=00/shift=01, write/writenum=2/done.
REQ-030 SHALL: CMP rn=4 rm=5 -> third cycle loads=1, ALUop=01, done=1; write never asserted.
REQ-031 SHALL: op=111 -> one cycle done=1, err=1, all strobes 0; with DPSEQ_CMD_COUNT_EN cmd_count increments by 1.
REQ-032 SHALL: reset asserted during EXEC of ADD -> outputs 0 and cmd_ready=1 without waiting for clk; no write issued afterwards.
REQ-033 SHALL: cmd_valid held high with two queued commands (MOV rd=1 rm=7, then AND rd=6) -> second accepted only the cycle after first done; cmd_rd changes during busy ignored.

Source files
------------

// File: rtl/datapath_sequencer.sv
// Multi-cycle command sequencer producing register-file / ALU datapath control strobes.
// Optional feature: define DPSEQ_CMD_COUNT_EN to enable the completed-command counter (cmd_count).
module datapath_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [2:0]  cmd_rd,
  input  logic [2:0]  cmd_rn,
  input  logic [2:0]  cmd_rm,
  input  logic [1:0]  cmd_shift,
  input  logic [7:0]  cmd_imm,
  output logic [2:0]  readnum,
  output logic [2:0]  writenum,
  output logic        write,
  output logic        loada,
  output logic        loadb,
  output logic        loadc,
  output logic        loads,
  output logic        asel,
  output logic [1:0]  ALUop,
  output logic [1:0]  shift,
  output logic        vsel,
  output logic [15:0] sximm,
  output logic        done,
  output logic        err,
  output logic [15:0] cmd_count
);

  typedef enum logic [2:0] {
    StIdle, StRdA, StRdB, StExec, StWb, StWimm, StErr
  } state_e;

  localparam logic [2:0] OpMovi = 3'b000;
  localparam logic [2:0] OpMov  = 3'b001;
  localparam logic [2:0] OpAdd  = 3'b010;
  localparam logic [2:0] OpCmp  = 3'b011;
  localparam logic [2:0] OpAnd  = 3'b100;
  localparam logic [2:0] OpMvn  = 3'b101;

  state_e     state_q, state_d;
  logic [2:0] op_q, op_d, rd_q, rd_d, rn_q, rn_d, rm_q, rm_d;
  logic [1:0] sh_q, sh_d;
  logic [7:0] imm_q, imm_d;

  logic       ready_q, ready_d;
  logic [2:0] readnum_q, readnum_d, writenum_q, writenum_d;
  logic       write_q, write_d, done_q, done_d, err_q, err_d;
  logic       loada_q, loada_d, loadb_q, loadb_d, loadc_q, loadc_d, loads_q, loads_d;
  logic       asel_q, asel_d, vsel_q, vsel_d;
  logic [1:0] alu_op_q, alu_op_d, shift_q, shift_d;

  logic accept;
  assign accept = cmd_valid & ready_q;

  // Next state and command-field capture; fields only move on acceptance.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    rd_d    = rd_q;
    rn_d    = rn_q;
    rm_d    = rm_q;
    sh_d    = sh_q;
    imm_d   = imm_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          op_d  = cmd_op;
          rd_d  = cmd_rd;
          rn_d  = cmd_rn;
          rm_d  = cmd_rm;
          sh_d  = cmd_shift;
          imm_d = cmd_imm;
          case (cmd_op)
            OpMovi:               state_d = StWimm;
            OpMov, OpMvn:         state_d = StRdB;
            OpAdd, OpCmp, OpAnd:  state_d = StRdA;
            default:              state_d = StErr;
          endcase
        end
      end
      StRdA:  state_d = StRdB;
      StRdB:  state_d = StExec;
      StExec: state_d = (op_q == OpCmp) ? StIdle : StWb;
      StWb:   state_d = StIdle;
      StWimm: state_d = StIdle;
      StErr:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs are decoded from the next state so they register in step with it.
  always_comb begin
    ready_d    = (state_d == StIdle);
    readnum_d  = 3'b000;
    writenum_d = 3'b000;
    write_d    = 1'b0;
    loada_d    = 1'b0;
    loadb_d    = 1'b0;
    loadc_d    = 1'b0;
    loads_d    = 1'b0;
    asel_d     = 1'b0;
    vsel_d     = 1'b0;
    alu_op_d   = 2'b00;
    shift_d    = 2'b00;
    done_d     = 1'b0;
    err_d      = 1'b0;
    unique case (state_d)
      StRdA: begin
        readnum_d = rn_d;
        loada_d   = 1'b1;
      end
      StRdB: begin
        readnum_d = rm_d;
        loadb_d   = 1'b1;
      end
      StExec: begin
        shift_d = sh_d;
        asel_d  = (op_d == OpMov);
        case (op_d)
          OpCmp:   alu_op_d = 2'b01;
          OpAnd:   alu_op_d = 2'b10;
          OpMvn:   alu_op_d = 2'b11;
          default: alu_op_d = 2'b00;
        endcase
        if (op_d == OpCmp) begin
          loads_d = 1'b1;
          done_d  = 1'b1;
        end else begin
          loadc_d = 1'b1;
        end
      end
      StWb: begin
        writenum_d = rd_d;
        write_d    = 1'b1;
        done_d     = 1'b1;
      end
      StWimm: begin
        writenum_d = rd_d;
        vsel_d     = 1'b1;
        write_d    = 1'b1;
        done_d     = 1'b1;
      end
      StErr: begin
        done_d = 1'b1;
        err_d  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      op_q       <= 3'b000;
      rd_q       <= 3'b000;
      rn_q       <= 3'b000;
      rm_q       <= 3'b000;
      sh_q       <= 2'b00;
      imm_q      <= 8'h00;
      ready_q    <= 1'b1;
      readnum_q  <= 3'b000;
      writenum_q <= 3'b000;
      write_q    <= 1'b0;
      loada_q    <= 1'b0;
      loadb_q    <= 1'b0;
      loadc_q    <= 1'b0;
      loads_q    <= 1'b0;
      asel_q     <= 1'b0;
      vsel_q     <= 1'b0;
      alu_op_q   <= 2'b00;
      shift_q    <= 2'b00;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      rd_q       <= rd_d;
      rn_q       <= rn_d;
      rm_q       <= rm_d;
      sh_q       <= sh_d;
      imm_q      <= imm_d;
      ready_q    <= ready_d;
      readnum_q  <= readnum_d;
      writenum_q <= writenum_d;
      write_q    <= write_d;
      loada_q    <= loada_d;
      loadb_q    <= loadb_d;
      loadc_q    <= loadc_d;
      loads_q    <= loads_d;
      asel_q     <= asel_d;
      vsel_q     <= vsel_d;
      alu_op_q   <= alu_op_d;
      shift_q    <= shift_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign cmd_ready = ready_q;
  assign readnum   = readnum_q;
  assign writenum  = writenum_q;
  assign write     = write_q;
  assign loada     = loada_q;
  assign loadb     = loadb_q;
  assign loadc     = loadc_q;
  assign loads     = loads_q;
  assign asel      = asel_q;
  assign vsel      = vsel_q;
  assign ALUop     = alu_op_q;
  assign shift     = shift_q;
  assign done      = done_q;
  assign err       = err_q;
  assign sximm     = {{8{imm_q[7]}}, imm_q};

`ifdef DPSEQ_CMD_COUNT_EN
  // Counts on the edge closing each done cycle, so illegal ops are counted too.
  logic [15:0] count_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= 16'h0000;
    end else if (done_q) begin
      count_q <= count_q + 16'd1;
    end
  end
  assign cmd_count = count_q;
`else
  assign cmd_count = 16'h0000;
`endif

endmodule

// File: tb/tb_datapath_sequencer.sv
// Directed bench for datapath_sequencer: a command vector table plus hand-written
// cycle-exact sequences for MOVI/ADD timing, back-to-back acceptance and mid-command reset.
module tb_datapath_sequencer;

  logic        clk, reset, cmd_valid, cmd_ready;
  logic [2:0]  cmd_op, cmd_rd, cmd_rn, cmd_rm;
  logic [1:0]  cmd_shift;
  logic [7:0]  cmd_imm;
  logic [2:0]  readnum, writenum;
  logic        write, loada, loadb, loadc, loads, asel, vsel, done, err;
  logic [1:0]  ALUop, shift;
  logic [15:0] sximm, cmd_count;

  datapath_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_rd    (cmd_rd),
    .cmd_rn    (cmd_rn),
    .cmd_rm    (cmd_rm),
    .cmd_shift (cmd_shift),
    .cmd_imm   (cmd_imm),
    .readnum   (readnum),
    .writenum  (writenum),
    .write     (write),
    .loada     (loada),
    .loadb     (loadb),
    .loadc     (loadc),
    .loads     (loads),
    .asel      (asel),
    .ALUop     (ALUop),
    .shift     (shift),
    .vsel      (vsel),
    .sximm     (sximm),
    .done      (done),
    .err       (err),
    .cmd_count (cmd_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef DPSEQ_CMD_COUNT_EN
  localparam bit CountEn = 1'b1;
`else
  localparam bit CountEn = 1'b0;
`endif

  typedef struct {
    logic [2:0]  op, rd, rn, rm;
    logic [1:0]  sh;
    logic [7:0]  imm;
    int          lat, wrs;
    logic [2:0]  wnum;
    logic        vs, er;
    logic [1:0]  alu;
    logic        as;
    logic [1:0]  shx;
    logic [2:0]  ra, rb;
    logic [15:0] sx;
  } vec_t;

  int n_vec = 0;
  int n_fail = 0;
  int exp_dones = 0;
  vec_t vecs[9];

  logic [19:0] obs;
  assign obs = {cmd_ready, loada, loadb, loadc, loads, write, done, err, asel, vsel,
                readnum, writenum, ALUop, shift};

  function automatic logic [19:0] mk(input int rdy, la, lb, lc, ls, wr, dn, er, as, vs,
                                     input int rn, wn, alu, sh);
    return {1'(rdy), 1'(la), 1'(lb), 1'(lc), 1'(ls), 1'(wr), 1'(dn), 1'(er), 1'(as),
            1'(vs), 3'(rn), 3'(wn), 2'(alu), 2'(sh)};
  endfunction

  function automatic vec_t mkvec(input int op, rd, rn, rm, sh, imm, lat, wrs, wnum, vs, er,
                                 input int alu, as, shx, ra, rb, sx);
    vec_t v;
    v.op = 3'(op);   v.rd = 3'(rd);   v.rn = 3'(rn);   v.rm = 3'(rm);
    v.sh = 2'(sh);   v.imm = 8'(imm); v.lat = lat;     v.wrs = wrs;
    v.wnum = 3'(wnum); v.vs = 1'(vs); v.er = 1'(er);   v.alu = 2'(alu);
    v.as = 1'(as);   v.shx = 2'(shx); v.ra = 3'(ra);   v.rb = 3'(rb);
    v.sx = 16'(sx);
    return v;
  endfunction

  function automatic logic [15:0] exp_count();
    return CountEn ? 16'(exp_dones) : 16'h0000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic drive(input int op, rd, rn, rm, sh, imm);
    cmd_op = 3'(op); cmd_rd = 3'(rd); cmd_rn = 3'(rn); cmd_rm = 3'(rm);
    cmd_shift = 2'(sh); cmd_imm = 8'(imm);
  endtask

  // Starts and ends on a negedge with the sequencer idle.
  task automatic run_vec(input vec_t v, input int idx);
    int lat, wrs;
    logic [2:0] wnum, ra, rb;
    logic vs, er, as, busy_rdy;
    logic [1:0] alu, shx;
    logic [15:0] sx;
    logic [4:0] strb, strb_exp;
    bit got;
    lat = 0; wrs = 0; wnum = 0; ra = 0; rb = 0; vs = 0; er = 0; as = 0;
    alu = 0; shx = 0; sx = 0; strb = 0; busy_rdy = 0; got = 0;
    check($sformatf("v%0d ready_idle", idx), cmd_ready, 1);
    cmd_valid = 1'b1;
    drive(v.op, v.rd, v.rn, v.rm, v.sh, v.imm);
    @(negedge clk);
    // Scramble inputs while busy; the latched command must not change.
    cmd_valid = 1'b0;
    drive(3'b111, ~v.rd, ~v.rn, ~v.rm, ~v.sh, ~v.imm);
    for (int c = 1; c <= 8; c++) begin
      if (!got) begin
        busy_rdy |= cmd_ready;
        if (write) begin wrs++; wnum = writenum; vs = vsel; end
        if (loada) ra = readnum;
        if (loadb) rb = readnum;
        if (loadc || loads) begin alu = ALUop; as = asel; shx = shift; end
        if (done) begin
          got = 1; lat = c; er = err; sx = sximm;
          strb = {loada, loadb, loadc, loads, write};
        end
        @(negedge clk);
      end
    end
    if (got) exp_dones++;
    strb_exp = {3'b000, v.op == 3'b011, v.wrs != 0};
    check($sformatf("v%0d latency", idx), lat, v.lat);
    check($sformatf("v%0d write_count", idx), wrs, v.wrs);
    check($sformatf("v%0d writenum", idx), wnum, v.wnum);
    check($sformatf("v%0d vsel", idx), vs, v.vs);
    check($sformatf("v%0d err", idx), er, v.er);
    check($sformatf("v%0d aluop", idx), alu, v.alu);
    check($sformatf("v%0d asel", idx), as, v.as);
    check($sformatf("v%0d shift", idx), shx, v.shx);
    check($sformatf("v%0d readnum_a", idx), ra, v.ra);
    check($sformatf("v%0d readnum_b", idx), rb, v.rb);
    check($sformatf("v%0d sximm", idx), sx, v.sx);
    check($sformatf("v%0d done_strobes", idx), strb, strb_exp);
    check($sformatf("v%0d ready_busy", idx), busy_rdy, 0);
    check($sformatf("v%0d ready_after", idx), cmd_ready, 1);
    check($sformatf("v%0d cmd_count", idx), cmd_count, exp_count());
  endtask

  initial begin
    int wd;
    //             op rd rn rm sh imm    lat wr wn vs er alu as shx ra rb sx
    vecs[0] = mkvec(0, 3, 0, 0, 0, 'hF6, 1, 1, 3, 1, 0, 0, 0, 0, 0, 0, 'hFFF6);
    vecs[1] = mkvec(0, 7, 2, 5, 3, 'h05, 1, 1, 7, 1, 0, 0, 0, 0, 0, 0, 'h0005);
    vecs[2] = mkvec(1, 1, 0, 7, 2, 'h00, 3, 1, 1, 0, 0, 0, 1, 2, 0, 7, 'h0000);
    vecs[3] = mkvec(2, 2, 0, 1, 1, 'h00, 4, 1, 2, 0, 0, 0, 0, 1, 0, 1, 'h0000);
    vecs[4] = mkvec(3, 0, 4, 5, 0, 'h00, 3, 0, 0, 0, 0, 1, 0, 0, 4, 5, 'h0000);
    vecs[5] = mkvec(4, 6, 3, 2, 3, 'h7F, 4, 1, 6, 0, 0, 2, 0, 3, 3, 2, 'h007F);
    vecs[6] = mkvec(5, 5, 6, 4, 1, 'h80, 3, 1, 5, 0, 0, 3, 0, 1, 0, 4, 'hFF80);
    vecs[7] = mkvec(6, 2, 1, 1, 0, 'h00, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 'h0000);
    vecs[8] = mkvec(7, 4, 0, 0, 0, 'h80, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 'hFF80);

    reset = 1'b1;
    cmd_valid = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    #2;
    check("reset outputs", obs, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    check("reset sximm", sximm, 0);
    check("reset cmd_count", cmd_count, 0);
    @(negedge clk);
    reset = 1'b0;

    // ADD rd=2 rn=0 rm=1 shift=01, cycle by cycle
    cmd_valid = 1'b1;
    drive(2, 2, 0, 1, 1, 0);
    @(negedge clk); cmd_valid = 1'b0;
    check("add c1", obs, mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    check("add c2", obs, mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    @(negedge clk);
    check("add c3", obs, mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    @(negedge clk);
    check("add c4", obs, mk(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 2, 0, 0));
    @(negedge clk);
    exp_dones++;
    check("add c5", obs, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    check("add cmd_count", cmd_count, exp_count());

    for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

    // Back-to-back: MOV rd=1 rm=7 then AND rd=6 rn=2 rm=3 with cmd_valid held high
    cmd_valid = 1'b1;
    drive(1, 1, 0, 7, 0, 0);
    @(negedge clk);
    drive(4, 6, 2, 3, 0, 0);
    check("b2b c1", obs, mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 7, 0, 0, 0));
    @(negedge clk);
    check("b2b c2", obs, mk(0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    @(negedge clk);
    check("b2b c3", obs, mk(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1, 0, 0));
    @(negedge clk);
    check("b2b c4", obs, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clk);
    check("b2b c5", obs, mk(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0));
    cmd_valid = 1'b0;
    cmd_rd = 3'd0;
    @(negedge clk);
    check("b2b c6", obs, mk(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 3, 0, 0, 0));
    @(negedge clk);
    check("b2b c7", obs, mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0));
    @(negedge clk);
    check("b2b c8", obs, mk(0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 6, 0, 0));
    @(negedge clk);
    exp_dones += 2;
    check("b2b c9", obs, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    check("b2b cmd_count", cmd_count, exp_count());

    // Reset asserted during EXEC of an ADD
    cmd_valid = 1'b1;
    drive(2, 5, 1, 2, 0, 'h33);
    @(negedge clk); cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst exec loadc", loadc, 1);
    #1 reset = 1'b1;
    #1;
    exp_dones = 0;
    check("rst async outputs", obs, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    check("rst async sximm", sximm, 0);
    check("rst async cmd_count", cmd_count, exp_count());
    @(negedge clk);
    reset = 1'b0;
    wd = 0;
    for (int c = 0; c < 6; c++) begin
      if (write || done) wd++;
      @(negedge clk);
    end
    check("rst no write/done after", wd, 0);
    check("rst ready after", cmd_ready, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
